alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU control decoder. It merges ALUop/funct3/funct7 decode with the datapath in one execute unit.
- Adds SLT/SLTU and SLTI/SLTIU, plus an optional RV32M multiply/divide path.
- The multiply/divide path is iterative and multi-cycle, behind a valid/ready handshake, so the pipeline stalls on it.
- Sits in EX between the ID/EX register and the EX/MEM register.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8. Derived localparam SHAMT_W = log2(XLEN).
- ENABLE_M, 1, 1 = M-extension decoded and executed; 0 = M encodings flagged illegal.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- ALUop  in  2  00 I-type ALU, 01 add (load/store address), 10 R-type, 11 shift left logical
- ALUctrl_f3  in  3  funct3
- ALUctrl_f7  in  7  funct7
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or immediate
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept
- result  out  XLEN  registered result
- illegal  out  1  decoded op unsupported; qualified by out_valid
- out_valid  out  1  result/illegal valid
- out_ready  in  1  consumer takes result

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, result=0, illegal=0, out_valid=0, in_ready=1 from the next cycle.
  - Reset mid-BUSY or mid-DONE aborts the op silently; no out_valid is produced.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). Accept = in_valid & in_ready.
  - IDLE, accept of a single-cycle op -> DONE. result/illegal are registered at the accept edge, so out_valid is high in cycle T+1.
  - IDLE, accept of a M-iterative op -> BUSY. The iteration counter is loaded with XLEN-1.
  - BUSY: one step per cycle. When counter==0, go to DONE. out_valid rises at T+XLEN+1.
  - DONE: out_valid=1; result and illegal are held stable. On out_ready -> IDLE, with in_ready=1 the next cycle. Without out_ready, stay in DONE indefinitely.
  - in_valid while not ready is ignored; inputs are sampled only at accept.
- Decode, ALUop=00 (I-type):
  - f3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI. f7 is ignored for these.
  - f3 001 with f7=0000000 is SLLI.
  - f3 101 with f7=0000000 is SRLI; with f7=0100000 it is SRAI.
  - Any other f7 on 001/101 -> illegal.
- Decode, ALUop=01: ADD, irrespective of f3/f7.
- Decode, ALUop=11: SLL of op_a by op_b[SHAMT_W-1:0].
- Decode, ALUop=10 (R-type):
  - f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - f7=0100000: f3 000 SUB, 101 SRA; other f3 -> illegal.
  - f7=0000001 with ENABLE_M=1: f3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Any other f7 -> illegal.
- Illegal ops complete in one cycle with result=0 and illegal=1.
- Arithmetic and width rules:
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount is the low SHAMT_W bits of op_b.
  - SLT/SLTU return 1 or 0, zero-extended.
  - MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
  - Multiply uses iterative shift-add on magnitudes, with sign correction at DONE entry.
  - Divide uses restoring division on magnitudes. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Division special cases, single-cycle (T+1):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU remainder = op_a.
  - Signed overflow (op_a = most-negative, op_b = -1): DIV result = op_a; REM result = 0.
- Only the multiply, divide and remainder ops not covered by these special cases are M-iterative.

Test Plan:
- ALUop=10, f3=000, f7=0100000, a=5, b=7, out_ready=1 -> out_valid at T+1, result=0xFFFFFFFE, illegal=0; in_ready=1 at T+2.
- ALUop=00, f3=101, f7=0100000, a=0x80000000, b=4 -> result=0xF8000000. Same inputs with f7=0000000 -> result=0x08000000.
- ALUop=10, f7=0000001, f3=001 (MULH), a=0xFFFFFFFF, b=0x00000002 -> in_ready=0 for cycles T+1..T+33, out_valid at T+33, result=0xFFFFFFFF. Repeat with f3=011 (MULHU) -> result=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000 at T+1. DIVU b=0 -> result 0xFFFFFFFF. REM b=0 with a=0x1234 -> result 0x1234.
- DIV a=-7, b=2 -> result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF. Hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; in_valid pulses during this time are ignored.
- Start DIVU, drive rst_n=0 at T+10 -> out_valid stays 0 and in_ready=1 from T+11. ALUop=10, f7=0000011 -> illegal=1, result=0. ENABLE_M=0 build with f7=0000001 -> illegal=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: merged ALUop/funct3/funct7 decode, single-cycle integer ops,
// and an iterative RV32M multiply/divide path behind a valid/ready handshake.
//
// state  | meaning
// IDLE   | ready to accept a new op
// BUSY   | iterating multiply or divide, one bit per cycle
// DONE   | result/illegal held until the consumer takes it
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUop,
    input  logic [2:0]      ALUctrl_f3,
    input  logic [6:0]      ALUctrl_f7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_result;
    logic               r_illegal;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic               r_sa;
    logic               r_sb;
    logic [2:0]         r_f3;
    logic [SHAMT_W-1:0] r_cnt;

    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_add, w_sub, w_sll, w_srl, w_sra, w_slt, w_sltu;
    logic               w_b_zero, w_ovf;
    logic [XLEN-1:0]    w_sc_res;
    logic               w_illegal;
    logic               w_iter;

    assign w_shamt = op_b[SHAMT_W-1:0];
    assign w_add   = op_a + op_b;
    assign w_sub   = op_a - op_b;
    assign w_sll   = op_a << w_shamt;
    assign w_srl   = op_a >> w_shamt;
    assign w_sra   = $unsigned($signed(op_a) >>> w_shamt);
    assign w_slt   = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    assign w_sltu  = {{(XLEN-1){1'b0}}, (op_a < op_b)};
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // Divide-by-zero and signed overflow resolve here in one cycle; everything
    // else in the M group goes iterative.
    always_comb begin
        w_sc_res  = '0;
        w_illegal = 1'b0;
        w_iter    = 1'b0;
        case (ALUop)
            2'b00: begin
                case (ALUctrl_f3)
                    3'b000: w_sc_res = w_add;
                    3'b010: w_sc_res = w_slt;
                    3'b011: w_sc_res = w_sltu;
                    3'b100: w_sc_res = op_a ^ op_b;
                    3'b110: w_sc_res = op_a | op_b;
                    3'b111: w_sc_res = op_a & op_b;
                    3'b001: begin
                        if (ALUctrl_f7 == F7_BASE) w_sc_res  = w_sll;
                        else                       w_illegal = 1'b1;
                    end
                    default: begin
                        if (ALUctrl_f7 == F7_BASE)     w_sc_res  = w_srl;
                        else if (ALUctrl_f7 == F7_ALT) w_sc_res  = w_sra;
                        else                           w_illegal = 1'b1;
                    end
                endcase
            end
            2'b01: w_sc_res = w_add;
            2'b11: w_sc_res = w_sll;
            default: begin
                if (ALUctrl_f7 == F7_BASE) begin
                    case (ALUctrl_f3)
                        3'b000:  w_sc_res = w_add;
                        3'b001:  w_sc_res = w_sll;
                        3'b010:  w_sc_res = w_slt;
                        3'b011:  w_sc_res = w_sltu;
                        3'b100:  w_sc_res = op_a ^ op_b;
                        3'b101:  w_sc_res = w_srl;
                        3'b110:  w_sc_res = op_a | op_b;
                        default: w_sc_res = op_a & op_b;
                    endcase
                end else if (ALUctrl_f7 == F7_ALT) begin
                    case (ALUctrl_f3)
                        3'b000:  w_sc_res  = w_sub;
                        3'b101:  w_sc_res  = w_sra;
                        default: w_illegal = 1'b1;
                    endcase
                end else if (ENABLE_M && (ALUctrl_f7 == F7_MULDIV)) begin
                    case (ALUctrl_f3)
                        3'b100: begin
                            if (w_b_zero)   w_sc_res = '1;
                            else if (w_ovf) w_sc_res = op_a;
                            else            w_iter   = 1'b1;
                        end
                        3'b101: begin
                            if (w_b_zero) w_sc_res = '1;
                            else          w_iter   = 1'b1;
                        end
                        3'b110: begin
                            if (w_b_zero)   w_sc_res = op_a;
                            else if (w_ovf) w_sc_res = '0;
                            else            w_iter   = 1'b1;
                        end
                        3'b111: begin
                            if (w_b_zero) w_sc_res = op_a;
                            else          w_iter   = 1'b1;
                        end
                        default: w_iter = 1'b1;
                    endcase
                end else begin
                    w_illegal = 1'b1;
                end
            end
        endcase
    end

    logic            w_a_sgn, w_b_sgn;
    logic [XLEN-1:0] w_a_mag, w_b_mag;

    assign w_a_sgn = op_a[XLEN-1] & ((ALUctrl_f3 == 3'b001) || (ALUctrl_f3 == 3'b010) ||
                                     (ALUctrl_f3 == 3'b100) || (ALUctrl_f3 == 3'b110));
    assign w_b_sgn = op_b[XLEN-1] & ((ALUctrl_f3 == 3'b001) || (ALUctrl_f3 == 3'b100) ||
                                     (ALUctrl_f3 == 3'b110));
    assign w_a_mag = w_a_sgn ? ('0 - op_a) : op_a;
    assign w_b_mag = w_b_sgn ? ('0 - op_b) : op_b;

    // Multiply: {r_hi, r_lo} is the partial product with the multiplier shifting out of r_lo.
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi, w_mul_lo;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    logic [XLEN:0]   w_div_shift;
    logic [XLEN-1:0] w_div_sub, w_div_hi, w_div_lo;
    logic            w_div_ok;

    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_sub   = w_div_shift[XLEN-1:0] - r_b;
    assign w_div_hi    = w_div_ok ? w_div_sub : w_div_shift[XLEN-1:0];
    assign w_div_lo    = {r_lo[XLEN-2:0], w_div_ok};

    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_m_res;

    assign w_prod     = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = (r_sa ^ r_sb) ? ('0 - w_prod) : w_prod;
    assign w_quo_fix  = (r_sa ^ r_sb) ? ('0 - w_div_lo) : w_div_lo;
    assign w_rem_fix  = r_sa ? ('0 - w_div_hi) : w_div_hi;

    always_comb begin
        w_m_res = w_rem_fix;
        case (r_f3)
            3'b000:                 w_m_res = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_m_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_m_res = w_quo_fix;
            default:                w_m_res = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_f3      <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_iter) begin
                            r_state <= S_BUSY;
                            r_cnt   <= SHAMT_W'(XLEN - 1);
                            r_hi    <= '0;
                            r_lo    <= w_a_mag;
                            r_b     <= w_b_mag;
                            r_sa    <= w_a_sgn;
                            r_sb    <= w_b_sgn;
                            r_f3    <= ALUctrl_f3;
                        end else begin
                            r_state   <= S_DONE;
                            r_result  <= w_sc_res;
                            r_illegal <= w_illegal;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= r_f3[2] ? w_div_hi : w_mul_hi;
                    r_lo  <= r_f3[2] ? w_div_lo : w_mul_lo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= S_DONE;
                        r_result  <= w_m_res;
                        r_illegal <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign illegal   = r_illegal;
endmodule
